// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational IF lookup,
// EX-stage resolution/redirect, clocked training and saturating stats.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_uncond,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [XLEN-1:0] upd_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);
    localparam int INDEX_W = $clog2(ENTRIES);
    localparam int TAG_W   = XLEN - INDEX_W - 2;
    localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [XLEN-1:0]    target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];
    logic [31:0]        stat_br_q, stat_br_d;
    logic [31:0]        stat_mp_q, stat_mp_d;

    logic [INDEX_W-1:0] if_idx, upd_idx;
    logic [TAG_W-1:0]   if_tag, upd_tag;
    logic               if_hit, upd_hit;
    logic [XLEN-1:0]    if_seq, upd_seq, actual_pc, predicted_pc;

    // Lookup
    always_comb begin
        if_idx      = if_pc[INDEX_W+1:2];
        if_tag      = if_pc[XLEN-1:INDEX_W+2];
        if_seq      = if_pc + PC_INC;
        if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_taken  = if_hit && ctr_q[if_idx][1];
        pred_target = pred_taken ? target_q[if_idx] : if_seq;
    end

    // Resolution
    always_comb begin
        upd_seq      = upd_pc + PC_INC;
        actual_pc    = upd_taken ? upd_target : upd_seq;
        predicted_pc = upd_pred_taken ? upd_pred_target : upd_seq;
        mispredict   = upd_valid && (actual_pc != predicted_pc);
        redirect_pc  = upd_valid ? actual_pc : upd_seq;
    end

    // Training
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        upd_idx  = upd_pc[INDEX_W+1:2];
        upd_tag  = upd_pc[XLEN-1:INDEX_W+2];
        upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        if (upd_valid) begin
            if (upd_hit) begin
                if (upd_uncond)
                    ctr_d[upd_idx] = 2'b11;
                else if (upd_taken && ctr_q[upd_idx] != 2'b11)
                    ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
                else if (!upd_taken && ctr_q[upd_idx] != 2'b00)
                    ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
                if (upd_taken)
                    target_d[upd_idx] = upd_target;
            end else if (upd_taken) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target;
                ctr_d[upd_idx]    = upd_uncond ? 2'b11 : 2'b10;
            end
        end
        // Invalidate takes priority over a same-cycle allocate
        if (clear)
            valid_d = '0;
    end

    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (upd_valid && stat_br_q != 32'hFFFF_FFFF)
            stat_br_d = stat_br_q + 32'd1;
        if (mispredict && stat_mp_q != 32'hFFFF_FFFF)
            stat_mp_d = stat_mp_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= '0;
            stat_br_q <= '0;
            stat_mp_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else begin
            valid_q   <= valid_d;
            tag_q     <= tag_d;
            target_q  <= target_d;
            ctr_q     <= ctr_d;
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector table for branch_predictor plus hand-written reset corner.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] if_pc = '0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_uncond = 1'b0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_pred_taken = 1'b0;
    logic [31:0] upd_pred_target = '0;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    branch_predictor #(.ENTRIES(16), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .clear(clear), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_uncond(upd_uncond),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic [31:0] ifpc;
        logic        uv;
        logic [31:0] upc;
        logic        unc;
        logic        utk;
        logic [31:0] utgt;
        logic        uptk;
        logic [31:0] uptgt;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_mp;
        logic [31:0] e_rd;
        logic [31:0] e_br;
        logic [31:0] e_mis;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   passed = 0;

    task automatic add(input logic clr, input logic [31:0] ifpc, input logic uv,
                       input logic [31:0] upc, input logic unc, input logic utk,
                       input logic [31:0] utgt, input logic uptk, input logic [31:0] uptgt,
                       input logic e_pt, input logic [31:0] e_ptgt, input logic e_mp,
                       input logic [31:0] e_rd, input logic [31:0] e_br, input logic [31:0] e_mis);
        vec_t v;
        v = '{clr, ifpc, uv, upc, unc, utk, utgt, uptk, uptgt,
              e_pt, e_ptgt, e_mp, e_rd, e_br, e_mis};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    initial begin
        // clr ifpc  uv upc  unc tk tgt  ptk ptgt  | pt ptgt  mp rd  br mis
        add(0, 32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h4,   0, 0);   // 0 reset state
        add(0, 32'h100, 1, 32'h100, 0, 1, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80,  0, 0);   // 1 cold taken
        add(0, 32'h100, 1, 32'h100, 0, 0, 32'h0,   1, 32'h80,  1, 32'h80,  1, 32'h104, 1, 1);   // 2 nt, ctr 2->1
        add(0, 32'h100, 1, 32'h100, 0, 0, 32'h0,   0, 32'h104, 0, 32'h104, 0, 32'h104, 2, 2);   // 3 ctr 1->0
        add(0, 32'h100, 1, 32'h100, 0, 0, 32'h0,   0, 32'h104, 0, 32'h104, 0, 32'h104, 3, 2);   // 4 sat 0
        add(0, 32'h100, 1, 32'h100, 0, 0, 32'h0,   0, 32'h104, 0, 32'h104, 0, 32'h104, 4, 2);   // 5 sat 0
        add(0, 32'h100, 0, 32'h100, 0, 0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h104, 5, 2);   // 6 stats 5/2
        add(0, 32'h100, 1, 32'h100, 0, 1, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80,  5, 2);   // 7 ctr 0->1
        add(0, 32'h100, 1, 32'h100, 0, 1, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80,  6, 3);   // 8 ctr 1->2
        add(0, 32'h100, 1, 32'h100, 0, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h80,  7, 4);   // 9 correct
        add(0, 32'h100, 1, 32'h100, 0, 1, 32'h90,  1, 32'h80,  1, 32'h80,  1, 32'h90,  8, 4);   // 10 wrong target
        add(0, 32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   1, 32'h90,  0, 32'h4,   9, 5);   // 11 target updated
        add(0, 32'h100, 1, 32'h100, 0, 0, 32'h0,   1, 32'h90,  1, 32'h90,  1, 32'h104, 9, 5);   // 12 ctr 3->2
        add(0, 32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   1, 32'h90,  0, 32'h4,   10, 6);  // 13 hysteresis
        add(0, 32'h140, 1, 32'h140, 1, 1, 32'h20,  0, 32'h144, 0, 32'h144, 1, 32'h20,  10, 6);  // 14 alias jal
        add(0, 32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h4,   11, 7);  // 15 evicted
        add(0, 32'h140, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   1, 32'h20,  0, 32'h4,   11, 7);  // 16 new owner
        add(0, 32'h140, 1, 32'h140, 0, 0, 32'h0,   1, 32'h20,  1, 32'h20,  1, 32'h144, 11, 7);  // 17 ctr 3->2
        add(0, 32'h140, 1, 32'h140, 0, 0, 32'h0,   1, 32'h20,  1, 32'h20,  1, 32'h144, 12, 8);  // 18 ctr 2->1
        add(0, 32'h140, 1, 32'h140, 1, 1, 32'h24,  0, 32'h144, 0, 32'h144, 1, 32'h24,  13, 9);  // 19 jal hit -> 3
        add(0, 32'h140, 1, 32'h140, 0, 0, 32'h0,   1, 32'h24,  1, 32'h24,  1, 32'h144, 14, 10); // 20 ctr 3->2
        add(0, 32'h140, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   1, 32'h24,  0, 32'h4,   15, 11); // 21 still taken
        add(1, 32'h140, 1, 32'h100, 0, 1, 32'h80,  0, 32'h104, 1, 32'h24,  1, 32'h80,  15, 11); // 22 clear+alloc
        add(0, 32'h140, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h144, 0, 32'h4,   16, 12); // 23 cleared
        add(0, 32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h4,   16, 12); // 24 clear won
        add(0, 32'h200, 1, 32'h200, 0, 1, 32'h300, 0, 32'h204, 0, 32'h204, 1, 32'h300, 16, 12); // 25 same-cycle
        add(0, 32'h200, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   1, 32'h300, 0, 32'h4,   17, 13); // 26 next cycle
        add(0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 17, 13); // 27 wrap
        add(0, 32'h10,  0, 32'h10,  0, 1, 32'h80,  1, 32'h90,  0, 32'h14,  0, 32'h14,  17, 13); // 28 upd_valid=0
        add(0, 32'h10,  0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h14,  0, 32'h4,   17, 13); // 29 no training
        add(0, 32'h202, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   1, 32'h300, 0, 32'h4,   17, 13); // 30 pc[1:0] ignored

        #12 rst = 1'b1;
        foreach (vecs[i]) begin
            @(negedge clk);
            clear = vecs[i].clr;           if_pc = vecs[i].ifpc;
            upd_valid = vecs[i].uv;        upd_pc = vecs[i].upc;
            upd_uncond = vecs[i].unc;      upd_taken = vecs[i].utk;
            upd_target = vecs[i].utgt;     upd_pred_taken = vecs[i].uptk;
            upd_pred_target = vecs[i].uptgt;
            #1;
            chk($sformatf("v%0d pred_taken", i),  {31'b0, pred_taken}, {31'b0, vecs[i].e_pt});
            chk($sformatf("v%0d pred_target", i), pred_target, vecs[i].e_ptgt);
            chk($sformatf("v%0d mispredict", i),  {31'b0, mispredict}, {31'b0, vecs[i].e_mp});
            chk($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].e_rd);
            chk($sformatf("v%0d stat_branches", i), stat_branches, vecs[i].e_br);
            chk($sformatf("v%0d stat_mispredicts", i), stat_mispredicts, vecs[i].e_mis);
        end

        // Async reset between edges with an allocate in flight
        @(negedge clk);
        clear = 1'b0; if_pc = 32'h200; upd_valid = 1'b1; upd_pc = 32'h240;
        upd_uncond = 1'b1; upd_taken = 1'b1; upd_target = 32'h500;
        upd_pred_taken = 1'b0; upd_pred_target = 32'h0;
        #1 chk("pre-rst pred_taken", {31'b0, pred_taken}, 32'd1);
        #1 rst = 1'b0;
        #1 chk("async rst pred_taken", {31'b0, pred_taken}, 32'd0);
        chk("async rst pred_target", pred_target, 32'h204);
        chk("async rst stat_branches", stat_branches, 32'd0);
        chk("async rst stat_mispredicts", stat_mispredicts, 32'd0);
        @(negedge clk);
        upd_valid = 1'b0; rst = 1'b1; if_pc = 32'h240;
        #1 chk("discarded upd pred_taken", {31'b0, pred_taken}, 32'd0);
        chk("discarded upd pred_target", pred_target, 32'h244);
        @(negedge clk);
        #1 chk("post-rst stat_branches", stat_branches, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
